registro_param: RTL

Parametrised shift/rotate/load register with a built-in burst serializer. It generalises the fixed 4-bit register to ANCHO bits, shifts PASO bits per step, and adds an arithmetic-shift mode. It also has a self-timed burst mode that loads a word and streams it out PASO bits per cycle under a start/busy/done handshake. It sits between the parallel datapath and serial links in the practice designs.

---
 rtl/registro_param_if.sv | 27 ++
 rtl/registro_param.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/registro_param_if.sv
// Bundle of the datapath/handshake signals of registro_param.
// The master drives the controls and data; the slave (the register) returns q, s_out, busy and done.
interface registro_param_if #(
    parameter int ANCHO = 8,
    parameter int PASO  = 1
);
    logic             enb;
    logic             dir;
    logic [2:0]       modo;
    logic [PASO-1:0]  s_in;
    logic [ANCHO-1:0] d;
    logic             start;
    logic [ANCHO-1:0] q;
    logic [PASO-1:0]  s_out;
    logic             busy;
    logic             done;

    modport master (
        output enb, dir, modo, s_in, d, start,
        input  q, s_out, busy, done
    );

    modport slave (
        input  enb, dir, modo, s_in, d, start,
        output q, s_out, busy, done
    );
endinterface

// File: rtl/registro_param.sv
// Parametrised shift/rotate/load register with a self-timed burst serializer
// that streams a loaded word out PASO bits per enabled cycle.
module registro_param #(
    parameter int ANCHO = 8,
    parameter int PASO  = 1
) (
    input  logic            clk,
    input  logic            rst,
    registro_param_if.slave bus
);
    localparam int K  = ANCHO / PASO;
    localparam int CW = (K > 2) ? $clog2(K) : 1;
    localparam logic [CW-1:0]    ULTIMO = CW'(K - 1);
    localparam logic [CW-1:0]    UNO    = CW'(1);
    localparam logic [CW-1:0]    CERO_C = CW'(0);
    localparam logic [PASO-1:0]  CERO_P = {PASO{1'b0}};

    typedef enum logic [0:0] {
        INACTIVO  = 1'b0,
        TRANSMITE = 1'b1
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] q_q, q_d;
    logic [PASO-1:0]  s_out_q, s_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;

    function automatic logic [ANCHO-1:0] desplaza(input logic [ANCHO-1:0] v,
                                                  input logic             derecha,
                                                  input logic [PASO-1:0]  relleno);
        if (derecha) begin
            desplaza = {relleno, v[ANCHO-1:PASO]};
        end else begin
            desplaza = {v[ANCHO-PASO-1:0], relleno};
        end
    endfunction

    // Chunk that leaves the register when shifting in the given direction.
    function automatic logic [PASO-1:0] saliente(input logic [ANCHO-1:0] v,
                                                 input logic             derecha);
        if (derecha) begin
            saliente = v[PASO-1:0];
        end else begin
            saliente = v[ANCHO-1 -: PASO];
        end
    endfunction

    // Next-state logic for the register, serializer FSM and chunk counter.
    always_comb begin
        estado_d = estado_q;
        q_d      = q_q;
        s_out_d  = CERO_P;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        if (bus.enb) begin
            case (estado_q)
                INACTIVO: begin
                    case (bus.modo)
                        3'b000: begin
                            q_d     = desplaza(q_q, bus.dir, bus.s_in);
                            s_out_d = saliente(q_q, bus.dir);
                        end
                        3'b001: begin
                            q_d = desplaza(q_q, bus.dir, saliente(q_q, bus.dir));
                        end
                        3'b010: begin
                            q_d = bus.d;
                        end
                        3'b011: begin
                            if (bus.dir) begin
                                q_d = desplaza(q_q, 1'b1, {PASO{q_q[ANCHO-1]}});
                            end else begin
                                q_d = desplaza(q_q, 1'b0, CERO_P);
                            end
                            s_out_d = saliente(q_q, bus.dir);
                        end
                        3'b100: begin
                            if (bus.start) begin
                                q_d      = bus.d;
                                dir_d    = bus.dir;
                                cnt_d    = CERO_C;
                                busy_d   = 1'b1;
                                estado_d = TRANSMITE;
                            end else begin
                                q_d = q_q;
                            end
                        end
                        default: begin
                            q_d = q_q;
                        end
                    endcase
                end
                TRANSMITE: begin
                    // Inputs are ignored here; only the latched direction matters.
                    q_d     = desplaza(q_q, dir_q, CERO_P);
                    s_out_d = saliente(q_q, dir_q);
                    if (cnt_q == ULTIMO) begin
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        cnt_d    = CERO_C;
                        estado_d = INACTIVO;
                    end else begin
                        cnt_d = cnt_q + UNO;
                    end
                end
                default: begin
                    estado_d = INACTIVO;
                    busy_d   = 1'b0;
                    cnt_d    = CERO_C;
                end
            endcase
        end else begin
            s_out_d = CERO_P;
            done_d  = 1'b0;
        end
    end

    // State registers with synchronous reset taking priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= INACTIVO;
            q_q      <= {ANCHO{1'b0}};
            s_out_q  <= CERO_P;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= CERO_C;
            dir_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            q_q      <= q_d;
            s_out_q  <= s_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.s_out = s_out_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule
